// File: rtl/icache_dm.sv
`timescale 1ns/1ps
// Direct-mapped read-only I-cache: hit returns the 64B line 2 cycles after ic_enable; a miss fills over 8 x 64-bit beats.
// Memory stalls (reqack low, beat gaps) hold the FSM in place. The ICACHE_STATS_EN macro adds the hit/miss counter ports.
module icache_dm #(
  parameter int SETS  = 64,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 58 - IDX_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ic_enable,
  input  logic [63:0]  iaddr,
  output logic [511:0] idata,
  output logic         ic_done,
  input  logic         flush,
  output logic         mem_reqcyc,
  output logic [63:0]  mem_req,
  input  logic         mem_reqack,
  input  logic         mem_respcyc,
  input  logic [63:0]  mem_resp,
  output logic         mem_respack
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MREQ, S_FILL, S_RESP} state_t;

  state_t             r_state;
  logic [SETS-1:0]    r_valid;
  logic [57:0]        r_line;
  logic [2:0]         r_beat;
  logic               r_flush_pend;
  logic [511:0]       r_buf;
  logic [511:0]       r_data [SETS];
  logic [TAG_W-1:0]   r_tags [SETS];

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic               w_unused_ok;

  assign w_idx       = r_line[IDX_W-1:0];
  assign w_tag       = r_line[57:IDX_W];
  assign w_hit       = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
  assign mem_respack = mem_respcyc;
  assign w_unused_ok = &{1'b0, iaddr[5:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_line       <= '0;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
      r_buf        <= '0;
      idata        <= '0;
      ic_done      <= 1'b0;
      mem_reqcyc   <= 1'b0;
      mem_req      <= '0;
    end else begin
      ic_done <= 1'b0;
      if (flush) begin
        r_valid <= '0;
        if (r_state == S_MREQ || r_state == S_FILL || r_state == S_RESP)
          r_flush_pend <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (ic_enable) begin
            r_line  <= iaddr[63:6];
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            idata   <= r_data[w_idx];
            ic_done <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            mem_reqcyc <= 1'b1;
            mem_req    <= {r_line, 6'b0};
            r_state    <= S_MREQ;
          end
        end
        S_MREQ: begin
          if (mem_reqack) begin
            mem_reqcyc <= 1'b0;
            r_beat     <= '0;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_respcyc) begin
            r_buf[{r_beat, 6'b0} +: 64] <= mem_resp;
            r_beat <= r_beat + 3'd1;
            if (r_beat == 3'd7)
              r_state <= S_RESP;
          end
        end
        S_RESP: begin
          // A flush seen at any point during the fill leaves the line installed but invalid.
          if (!flush && !r_flush_pend)
            r_valid[w_idx] <= 1'b1;
          r_flush_pend <= 1'b0;
          idata        <= r_buf;
          ic_done      <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_RESP) begin
      r_data[w_idx] <= r_buf;
      r_tags[w_idx] <= w_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit)
        hit_cnt <= hit_cnt + 32'd1;
      else
        miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the instruction-fetch stage and the memory bus.
- Accepts single-cycle line-fetch pulses (ic_enable/iaddr) from fetch and returns a full 64-byte line on idata with a one-cycle ic_done pulse.
- On a miss, fetches the line over the 64-bit request/response memory bus in 8 beats, installs it, then responds.

Parameters:
- SETS, 64, number of 64-byte lines (power of 2, >=2).
- IDX_W, $clog2(SETS), index width.
- TAG_W, 58-IDX_W, tag width; tag = iaddr[63:6+IDX_W].

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- ic_enable  in  1  fetch request pulse; iaddr is sampled with it.
- iaddr  in  64  fetch address; bits [5:0] are ignored.
- idata  out  512  returned line; byte i of line = idata[i*8+:8].
- ic_done  out  1  one-cycle pulse; idata is valid.
- flush  in  1  invalidate all lines.
- mem_reqcyc  out  1  memory read request valid.
- mem_req  out  64  line-aligned request address.
- mem_reqack  in  1  request accepted.
- mem_respcyc  in  1  response beat valid.
- mem_resp  in  64  response beat; beat k = line bytes 8k..8k+7, little-endian.
- mem_respack  out  1  beat accepted; equals mem_respcyc combinationally.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all valid bits 0; ic_done=0; idata=0; mem_reqcyc=0; mem_req=0; beat counter 0; flush_pend=0. Data/tag arrays need no reset.
- States: IDLE, LOOKUP, MREQ, FILL, RESP.
- IDLE: ic_enable=1 latches {tag,index} from iaddr and goes to LOOKUP. ic_enable in any other state is ignored; fetch issues only one outstanding request.
- LOOKUP: compares the valid bit and stored tag at the index.
  - Hit: idata <= array line, ic_done=1 for one cycle, then IDLE. Hit latency is 2 cycles from the ic_enable edge to the ic_done edge.
  - Miss: mem_reqcyc<=1, mem_req<={iaddr[63:6],6'b0}, go to MREQ.
- MREQ: hold mem_reqcyc and mem_req stable until mem_reqack=1 is sampled, then drop mem_reqcyc and go to FILL with beat count 0.
- FILL: each cycle mem_respcyc=1 writes mem_resp into line buffer bits [k*64+:64] and increments k (3 bits). Gaps between beats are allowed. On beat 7, go to RESP.
- RESP: write the buffer to the data array and the tag to the tag array. Set valid[index]=1 unless flush_pend or flush is asserted now. idata<=buffer, ic_done=1 for one cycle, clear flush_pend, go to IDLE.
- Miss latency: 3 cycles plus arbitration plus beat cycles.
- flush: clears all valid bits the same cycle, in any state.
  - flush during MREQ/FILL/RESP sets flush_pend; the in-flight line is still returned on ic_done but is not marked valid.
  - flush with ic_enable in IDLE: the request is accepted and looks up after the clear, so it misses.
- ic_done is never high two consecutive cycles. idata holds its value until the next ic_done.
- mem_respcyc outside FILL is acked and ignored.
- Index wrap: addresses differing only in the tag evict each other; no other replacement.

Optional Feature:
- ICACHE_STATS_EN:
  - Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0], reset to 0. They increment in LOOKUP on hit or miss, wrap at 2^32, and are unaffected by flush.
  - Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Cold miss: reset, pulse ic_enable with iaddr=0x1000_0040. Expect mem_req=0x1000_0040. Bench acks, sends beats 0x0706050403020100 (+0x0808080808080808 per beat). Then ic_done once, idata[7:0]=0x00, idata[511:504]=0x3F.
- Hit: repeat the same iaddr with offset 0x25. Expect ic_done 2 cycles after ic_enable, no mem_reqcyc, same idata.
- Conflict: request 0x1000_0040, then 0x2000_0040 (same index, SETS=64). Expect both to miss; then 0x1000_0040 misses again.
- Flush mid-fill: assert flush between beats 3 and 4. Expect ic_done with the correct line, then the same address misses again.
- Backpressure and gaps: hold mem_reqack=0 for 5 cycles and insert 2-cycle gaps between beats. Expect mem_req stable and a correct line assembled.
- Async reset mid-FILL: reset_n low for 1 cycle. Expect mem_reqcyc=0 and ic_done=0 immediately; the next request to that address misses.
